// File: rtl/aes_ctr_block_gen_if.sv
// Purpose: request/response bundle between the AES-CTR counter-block generator
//          and its controller / round pipeline.
// Signals:
//   start, iv, num_blocks, stall        - run request and back-pressure (master -> slave)
//   ctr_block, ctr_valid                - counter block to the round pipeline input
//   ks_valid, ks_last                   - keystream qualifiers aligned to the pipeline output
//   busy, done, ctr_wrap                - run status
interface aes_ctr_block_gen_if #(
   parameter int unsigned BLOCK_SIZE = 128,
   parameter int unsigned CNT_WIDTH  = 16
);
   logic                  start;
   logic [BLOCK_SIZE-1:0] iv;
   logic [CNT_WIDTH-1:0]  num_blocks;
   logic                  stall;
   logic [BLOCK_SIZE-1:0] ctr_block;
   logic                  ctr_valid;
   logic                  ks_valid;
   logic                  ks_last;
   logic                  busy;
   logic                  done;
   logic                  ctr_wrap;

   modport master (
      output start, iv, num_blocks, stall,
      input  ctr_block, ctr_valid, ks_valid, ks_last, busy, done, ctr_wrap
   );

   modport slave (
      input  start, iv, num_blocks, stall,
      output ctr_block, ctr_valid, ks_valid, ks_last, busy, done, ctr_wrap
   );
endinterface

// File: rtl/aes_ctr_block_gen.sv
// Purpose: counter-block generator feeding the unrolled AES-256 round pipeline.
//          Issues one counter block per unstalled cycle, increments the low
//          CTR_WIDTH bits (nonce untouched), and tracks the fixed pipeline
//          latency so keystream cycles and the final block are flagged.
// Ports:
//   clk    - rising-edge clock
//   rst_n  - asynchronous active-low reset
//   bus    - aes_ctr_block_gen_if.slave (start/iv/num_blocks/stall in;
//            ctr_block/ctr_valid/ks_valid/ks_last/busy/done/ctr_wrap out)
module aes_ctr_block_gen #(
   parameter int unsigned BLOCK_SIZE = 128,
   parameter int unsigned CTR_WIDTH  = 32,
   parameter int unsigned LATENCY    = 7,
   parameter int unsigned CNT_WIDTH  = 16
) (
   input  logic               clk,
   input  logic               rst_n,
   aes_ctr_block_gen_if.slave bus
);

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_RUN   = 2'd1,
      S_DRAIN = 2'd2
   } state_t;

   state_t                state_q;
   logic [BLOCK_SIZE-1:0] ctr_q;
   logic [BLOCK_SIZE-1:0] ctr_block_q;
   logic [CNT_WIDTH-1:0]  remaining_q;
   logic                  ctr_valid_q;
   logic                  ctr_last_q;
   logic                  busy_q;
   logic                  done_q;
   logic                  wrap_q;
   logic [LATENCY-1:0]    vpipe_q;
   logic [LATENCY-1:0]    lpipe_q;

   logic [CTR_WIDTH-1:0]  ctr_lo_inc_c;
   logic                  ctr_lo_max_c;
   logic                  issue_c;
   logic                  last_issue_c;
   logic                  ks_end_c;

   // Counter low-field increment; the nonce above CTR_WIDTH is carried through.
   assign ctr_lo_inc_c = ctr_q[CTR_WIDTH-1:0] + CTR_WIDTH'(1);
   assign ctr_lo_max_c = &ctr_q[CTR_WIDTH-1:0];

   // Issue decision for this edge.
   assign issue_c      = (state_q == S_RUN) && !bus.stall && (remaining_q != '0);
   assign last_issue_c = (remaining_q == CNT_WIDTH'(1));

   // Final keystream block leaving the round pipeline ends the drain.
   assign ks_end_c     = vpipe_q[LATENCY-1] & lpipe_q[LATENCY-1];

   // Control FSM, counter datapath and latency-matching shift registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= S_IDLE;
         ctr_q       <= '0;
         ctr_block_q <= '0;
         remaining_q <= '0;
         ctr_valid_q <= 1'b0;
         ctr_last_q  <= 1'b0;
         busy_q      <= 1'b0;
         done_q      <= 1'b0;
         wrap_q      <= 1'b0;
         vpipe_q     <= '0;
         lpipe_q     <= '0;
      end else begin
         // The round pipeline never stalls, so the trackers shift every cycle.
         vpipe_q     <= {vpipe_q[LATENCY-2:0], ctr_valid_q};
         lpipe_q     <= {lpipe_q[LATENCY-2:0], ctr_last_q};
         ctr_valid_q <= 1'b0;
         ctr_last_q  <= 1'b0;
         done_q      <= 1'b0;

         case (state_q)
            S_IDLE: begin
               if (bus.start) begin
                  if (bus.num_blocks != '0) begin
                     ctr_q       <= bus.iv;
                     remaining_q <= bus.num_blocks;
                     wrap_q      <= 1'b0;
                     busy_q      <= 1'b1;
                     state_q     <= S_RUN;
                  end else begin
                     // Empty request completes immediately without issuing.
                     done_q      <= 1'b1;
                  end
               end
            end

            S_RUN: begin
               // A stalled cycle leaves ctr_block, counter and remaining as they are.
               if (issue_c) begin
                  ctr_block_q <= ctr_q;
                  ctr_valid_q <= 1'b1;
                  ctr_last_q  <= last_issue_c;
                  ctr_q       <= {ctr_q[BLOCK_SIZE-1:CTR_WIDTH], ctr_lo_inc_c};
                  remaining_q <= remaining_q - CNT_WIDTH'(1);
                  if (ctr_lo_max_c) begin
                     wrap_q <= 1'b1;
                  end
                  if (last_issue_c) begin
                     state_q <= S_DRAIN;
                  end
               end
            end

            S_DRAIN: begin
               if (ks_end_c) begin
                  done_q  <= 1'b1;
                  busy_q  <= 1'b0;
                  state_q <= S_IDLE;
               end
            end

            default: begin
               state_q <= S_IDLE;
            end
         endcase
      end
   end

   // Output mapping; every output comes straight from a register.
   assign bus.ctr_block = ctr_block_q;
   assign bus.ctr_valid = ctr_valid_q;
   assign bus.ks_valid  = vpipe_q[LATENCY-1];
   assign bus.ks_last   = lpipe_q[LATENCY-1];
   assign bus.busy      = busy_q;
   assign bus.done      = done_q;
   assign bus.ctr_wrap  = wrap_q;

endmodule

// File: tb/tb_aes_ctr_block_gen.sv
// Purpose: self-checking bench for aes_ctr_block_gen. A run-level model fills
//          per-cycle expectation tables from (start cycle, iv, N, stall cycles);
//          a negedge process compares every output against them each cycle,
//          and directed literal checks pin key cycles of each scenario.
module tb_aes_ctr_block_gen;

   localparam int unsigned BLOCK_SIZE = 128;
   localparam int unsigned CNT_WIDTH  = 16;
   localparam int          LAT        = 7;
   localparam int          MAXC       = 1024;

   logic clk;
   logic rst_n;
   logic stall_q;

   aes_ctr_block_gen_if #(.BLOCK_SIZE(BLOCK_SIZE), .CNT_WIDTH(CNT_WIDTH)) bus ();

   aes_ctr_block_gen #(
      .BLOCK_SIZE(BLOCK_SIZE),
      .CTR_WIDTH (32),
      .LATENCY   (LAT),
      .CNT_WIDTH (CNT_WIDTH)
   ) dut (
      .clk  (clk),
      .rst_n(rst_n),
      .bus  (bus)
   );

   assign bus.stall = stall_q;

   int n_vec = 0;
   int n_err = 0;
   int cyc   = 0;

   bit         stall_at  [MAXC];
   bit         exp_valid [MAXC];
   logic [127:0] exp_block [MAXC];
   bit         exp_ks    [MAXC];
   bit         exp_last  [MAXC];
   bit         exp_done  [MAXC];
   bit         exp_busy  [MAXC];
   bit         exp_wrap  [MAXC];

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Cycle counter and stall driver, updated just after each rising edge.
   initial stall_q = 1'b0;
   always @(posedge clk) begin
      cyc <= cyc + 1;
      #1 stall_q = (cyc < MAXC) ? stall_at[cyc] : 1'b0;
   end

   task automatic chk1(input string name, input logic act, input bit exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s cycle %0d: got %b expected %b", name, cyc, act, exp);
      end
   endtask

   task automatic chkw(input string name, input logic [127:0] act, input logic [127:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s cycle %0d: got %h expected %h", name, cyc, act, exp);
      end
   endtask

   // Run-level model: block k is the iv with k added to its low word, issued
   // on the first unstalled RUN cycle after block k-1; keystream follows LAT
   // cycles after ctr_valid, done one cycle after the last keystream.
   task automatic model_run(input int s, input logic [127:0] iv0, input int n, output int d);
      int c, k, last_ks;
      logic [31:0] lo;
      if (n == 0) begin
         exp_done[s+1] = 1'b1;
         d = s + 1;
         return;
      end
      for (int i = s + 1; i < MAXC; i++) exp_wrap[i] = 1'b0;
      c = s + 1;
      k = 0;
      last_ks = s;
      while (k < n) begin
         if (!stall_at[c]) begin
            lo = iv0[31:0] + 32'(k);
            exp_valid[c+1] = 1'b1;
            exp_block[c+1] = {iv0[127:32], lo};
            exp_ks[c+1+LAT] = 1'b1;
            if (k == n - 1) begin
               exp_last[c+1+LAT] = 1'b1;
               last_ks = c + 1 + LAT;
            end
            // Stepping past all-ones wraps the low word.
            if (lo == 32'hFFFF_FFFF) begin
               for (int i = c + 1; i < MAXC; i++) exp_wrap[i] = 1'b1;
            end
            k++;
         end
         c++;
      end
      for (int i = s + 1; i <= last_ks; i++) exp_busy[i] = 1'b1;
      exp_done[last_ks+1] = 1'b1;
      d = last_ks + 1;
   endtask

   task automatic model_reset(input int r);
      for (int i = r; i < MAXC; i++) begin
         exp_valid[i] = 1'b0;
         exp_ks[i]    = 1'b0;
         exp_last[i]  = 1'b0;
         exp_done[i]  = 1'b0;
         exp_busy[i]  = 1'b0;
         exp_wrap[i]  = 1'b0;
      end
   endtask

   // Per-cycle comparison against the model tables.
   always @(negedge clk) begin
      if (cyc < MAXC) begin
         chk1("ctr_valid", bus.ctr_valid, exp_valid[cyc]);
         chk1("ks_valid",  bus.ks_valid,  exp_ks[cyc]);
         chk1("ks_last",   bus.ks_last,   exp_last[cyc]);
         chk1("done",      bus.done,      exp_done[cyc]);
         chk1("busy",      bus.busy,      exp_busy[cyc]);
         chk1("ctr_wrap",  bus.ctr_wrap,  exp_wrap[cyc]);
         if (exp_valid[cyc]) chkw("ctr_block", bus.ctr_block, exp_block[cyc]);
      end
   end

   // Advance to 1 time unit after the rising edge that starts cycle c.
   task automatic goto_cyc(input int c);
      while (cyc < c) begin
         @(posedge clk);
         #1;
      end
   endtask

   // Advance to the sampling point (falling edge) of cycle c.
   task automatic goto_neg(input int c);
      goto_cyc(c);
      @(negedge clk);
   endtask

   task automatic do_start(input logic [127:0] iv0, input int n, output int s, output int d);
      goto_cyc(cyc + 1);
      s = cyc;
      bus.start      = 1'b1;
      bus.iv         = iv0;
      bus.num_blocks = CNT_WIDTH'(n);
      model_run(s, iv0, n, d);
      goto_cyc(cyc + 1);
      bus.start = 1'b0;
   endtask

   localparam logic [127:0] IV_BASIC = 128'h0001_0203_0405_0607_0809_0A0B_0000_0005;
   localparam logic [127:0] IV_WRAP  = 128'hA5A5_5A5A_DEAD_BEEF_1234_5678_FFFF_FFFE;
   localparam logic [127:0] IV_OTHER = 128'hCAFE_0000_0000_0000_0000_0001_7777_0000;

   initial begin
      int s, d;
      rst_n          = 1'b0;
      bus.start      = 1'b0;
      bus.iv         = '0;
      bus.num_blocks = '0;
      repeat (3) @(posedge clk);
      #1 rst_n = 1'b1;
      goto_cyc(cyc + 2);

      // Basic three-block run.
      do_start(IV_BASIC, 3, s, d);
      goto_neg(s + 2);
      chkw("basic_first_block", bus.ctr_block, 128'h0001_0203_0405_0607_0809_0A0B_0000_0005);
      goto_neg(s + 4);
      chkw("basic_third_block", bus.ctr_block, 128'h0001_0203_0405_0607_0809_0A0B_0000_0007);
      goto_neg(s + 11);
      chk1("basic_ks_last", bus.ks_last, 1'b1);
      goto_neg(s + 12);
      chk1("basic_done", bus.done, 1'b1);
      chk1("basic_wrap", bus.ctr_wrap, 1'b0);
      goto_cyc(d + 3);

      // Four blocks with one stalled issue slot.
      stall_at[cyc + 4] = 1'b1;
      do_start(IV_BASIC, 4, s, d);
      goto_neg(s + 4);
      chk1("stall_bubble", bus.ctr_valid, 1'b0);
      goto_neg(s + 5);
      chkw("stall_resume_block", bus.ctr_block, 128'h0001_0203_0405_0607_0809_0A0B_0000_0007);
      goto_neg(s + 11);
      chk1("stall_ks_bubble", bus.ks_valid, 1'b0);
      goto_neg(s + 14);
      chk1("stall_done", bus.done, 1'b1);
      goto_cyc(d + 3);

      // Zero-length request.
      do_start(IV_BASIC, 0, s, d);
      goto_neg(s + 1);
      chk1("zero_done", bus.done, 1'b1);
      chk1("zero_busy", bus.busy, 1'b0);
      goto_cyc(d + 3);

      // Start pulsed while busy is ignored.
      do_start(IV_BASIC, 5, s, d);
      goto_cyc(s + 4);
      bus.start      = 1'b1;
      bus.iv         = IV_OTHER;
      bus.num_blocks = CNT_WIDTH'(2);
      goto_cyc(s + 5);
      bus.start = 1'b0;
      goto_neg(s + 6);
      chkw("busy_start_block", bus.ctr_block, 128'h0001_0203_0405_0607_0809_0A0B_0000_0009);
      goto_neg(s + 14);
      chk1("busy_start_done", bus.done, 1'b1);
      goto_cyc(d + 3);

      // Counter low word wraps mid-run.
      do_start(IV_WRAP, 3, s, d);
      goto_neg(s + 3);
      chkw("wrap_second_block", bus.ctr_block, 128'hA5A5_5A5A_DEAD_BEEF_1234_5678_FFFF_FFFF);
      goto_neg(s + 4);
      chkw("wrap_third_block", bus.ctr_block, 128'hA5A5_5A5A_DEAD_BEEF_1234_5678_0000_0000);
      goto_neg(d);
      chk1("wrap_sticky_at_done", bus.ctr_wrap, 1'b1);
      goto_cyc(d + 3);

      // Reset in the middle of a ten-block run.
      do_start(IV_BASIC, 10, s, d);
      goto_neg(s + 1);
      chk1("wrap_cleared_by_start", bus.ctr_wrap, 1'b0);
      goto_cyc(s + 3);
      rst_n = 1'b0;
      model_reset(s + 3);
      @(negedge clk);
      chk1("reset_valid_cleared", bus.ctr_valid, 1'b0);
      chk1("reset_busy_cleared", bus.busy, 1'b0);
      goto_cyc(s + 5);
      rst_n = 1'b1;
      goto_cyc(s + 25);

      // Post-reset run matches the basic run.
      do_start(IV_BASIC, 3, s, d);
      goto_neg(s + 2);
      chkw("post_reset_first_block", bus.ctr_block, 128'h0001_0203_0405_0607_0809_0A0B_0000_0005);
      goto_neg(s + 12);
      chk1("post_reset_done", bus.done, 1'b1);
      goto_cyc(d + 4);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
